// File: rtl/dither_pixel_packer.sv
// Packs 4-pixel dithered groups into 32-bit words; optional line flush via DITHER_PACK_LINE_FLUSH_EN.
// Latency 1 cycle from completing accept to vout_valid; stalls vin only on the completing slot.
module dither_pixel_packer #(
  parameter int OUTPUT_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUTPUT_BITS*4-1:0]  vin,
  input  logic                      vin_valid,
  output logic                      vin_ready,
  input  logic                      vin_eol,
  output logic [31:0]               vout,
  output logic                      vout_valid,
  input  logic                      vout_ready,
  output logic                      vout_eol
);
  localparam int GW  = OUTPUT_BITS * 4;
  localparam int GPW = 32 / GW;
  localparam int CW  = (GPW > 1) ? $clog2(GPW) : 1;

  logic [CW-1:0] cnt;
  logic [31:0]   acc;
  logic [31:0]   slot_word;
  logic [5:0]    shamt;
  logic          last_slot;
  logic          completing_slot;
  logic          accept;
  logic          complete;

  assign last_slot = (cnt == CW'(GPW - 1));

`ifdef DITHER_PACK_LINE_FLUSH_EN
  assign completing_slot = last_slot || vin_eol;
`else
  logic unused_eol;
  assign unused_eol      = vin_eol;
  assign completing_slot = last_slot;
`endif

  // Only the word-closing group has to wait for the output register.
  assign vin_ready = !completing_slot || !vout_valid || vout_ready;
  assign accept    = vin_valid && vin_ready;
  assign complete  = accept && completing_slot;

  // Group placed in its slot with every other bit zero, so it can be OR-ed in.
  assign shamt     = 6'(cnt) * 6'(GW);
  assign slot_word = {vin, {(32 - GW){1'b0}}} >> shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      vout       <= '0;
      vout_valid <= 1'b0;
    end else if (complete) begin
      vout       <= acc | slot_word;
      vout_valid <= 1'b1;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      if (vout_valid && vout_ready)
        vout_valid <= 1'b0;
      if (accept) begin
        acc <= acc | slot_word;
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DITHER_PACK_LINE_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vout_eol <= 1'b0;
    else if (complete)
      vout_eol <= vin_eol;
  end
`else
  assign vout_eol = 1'b0;
`endif

endmodule

// File: tb/tb_dither_pixel_packer.sv
// Bench for dither_pixel_packer: directed cases plus random traffic against a word-level reference model.
module tb_dither_pixel_packer;
`ifdef DITHER_PACK_LINE_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam int GW1  = 4;
  localparam int GPW1 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vin;
  logic        vin_valid, vin_ready, vin_eol;
  logic [31:0] vout;
  logic        vout_valid, vout_ready, vout_eol;

  logic [15:0] v4_in;
  logic        v4_valid, v4_ready, v4_eol;
  logic [31:0] v4_out;
  logic        v4_ovalid, v4_oready, v4_oeol;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [31:0] part;
  int          n;
  logic        acc_flag;

  always #5 clk = ~clk;

  dither_pixel_packer #(.OUTPUT_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .vin(vin), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vin_eol(vin_eol), .vout(vout), .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_eol(vout_eol)
  );

  dither_pixel_packer #(.OUTPUT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .vin(v4_in), .vin_valid(v4_valid), .vin_ready(v4_ready),
    .vin_eol(v4_eol), .vout(v4_out), .vout_valid(v4_ovalid), .vout_ready(v4_oready),
    .vout_eol(v4_oeol)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part = '0;
    n    = 0;
  endtask

  // Groups are shifted in as a pixel string; a closed word is left-justified with zero fill.
  task automatic model_accept(input logic [3:0] g, input logic eol);
    logic closes;
    part   = (part << GW1) | 32'(g);
    n      = n + 1;
    closes = (n == GPW1) || (FLUSH && eol);
    if (closes) begin
      exp_q.push_back({FLUSH && eol, part << ((GPW1 - n) * GW1)});
      part = '0;
      n    = 0;
    end
  endtask

  // One clock: check against the model before the edge, then advance the model.
  task automatic cyc();
    logic comp, er;
    @(negedge clk);
    comp = (n == GPW1 - 1) || (FLUSH && vin_eol);
    er   = !comp || (exp_q.size() == 0) || vout_ready;
    chk("vin_ready", 32'(vin_ready), 32'(er));
    chk("vout_valid", 32'(vout_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("vout", vout, exp_q[0][31:0]);
      chk("vout_eol", 32'(vout_eol), 32'(exp_q[0][32]));
    end
    acc_flag = vin_valid && er;
    if (exp_q.size() != 0 && vout_ready)
      void'(exp_q.pop_front());
    if (acc_flag)
      model_accept(vin, vin_eol);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] g, input logic eol);
    vin = g; vin_eol = eol; vin_valid = 1'b1;
    cyc();
    vin_valid = 1'b0; vin_eol = 1'b0;
  endtask

  initial begin
    int gi;
    rst = 1'b1;
    vin = '0; vin_valid = 1'b0; vin_eol = 1'b0; vout_ready = 1'b1;
    v4_in = '0; v4_valid = 1'b0; v4_eol = 1'b0; v4_oready = 1'b1;
    model_reset();
    #2;
    chk("rst_vout", vout, 32'h0);
    chk("rst_valid", 32'(vout_valid), 32'h0);
    chk("rst_eol", 32'(vout_eol), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4-bit pixels: two groups fill a word.
    v4_valid = 1'b1; v4_in = 16'hABCD;
    @(posedge clk); #1;
    v4_in = 16'h1234;
    @(posedge clk); #1;
    v4_valid = 1'b0;
    chk("w4_valid", 32'(v4_ovalid), 32'h1);
    chk("w4_word", v4_out, 32'hABCD1234);
    @(posedge clk); #1;
    chk("w4_drained", 32'(v4_ovalid), 32'h0);

    // Eight consecutive groups, output always ready.
    for (int i = 1; i <= 8; i++) begin
      vin = 4'(i); vin_valid = 1'b1; vin_eol = 1'b0;
      cyc();
      if (i < 8) chk("seq_no_early", 32'(vout_valid), 32'h0);
    end
    vin_valid = 1'b0;
    chk("seq_word", vout, 32'h12345678);
    chk("seq_valid", 32'(vout_valid), 32'h1);
    cyc();
    chk("seq_one_cycle", 32'(vout_valid), 32'h0);

    // Output stalled while 16 groups are offered.
    vout_ready = 1'b0;
    gi = 0;
    for (int c = 0; c < 24; c++) begin
      vin = 4'(gi + 3); vin_valid = 1'b1;
      cyc();
      if (acc_flag) gi++;
    end
    chk("stall_accepts", 32'(gi), 32'd15);
    chk("stall_held", vout, 32'h3456789A);
    @(negedge clk);
    chk("stall_rdy_low", 32'(vin_ready), 32'h0);
    @(posedge clk); #1;
    vout_ready = 1'b1;
    cyc();
    chk("stall_release_acc", 32'(acc_flag), 32'h1);
    vin_valid = 1'b0;
    chk("stall_word2", vout, 32'hBCDEF012);
    chk("stall_word2_vld", 32'(vout_valid), 32'h1);
    cyc();

    // Line end after three groups.
    feed(4'hF, 1'b0);
    feed(4'hE, 1'b0);
    feed(4'hD, 1'b1);
    if (FLUSH) begin
      chk("flush_word", vout, 32'hFED00000);
      chk("flush_eol", 32'(vout_eol), 32'h1);
    end else begin
      chk("noflush_pending", 32'(vout_valid), 32'h0);
    end
    for (int i = 1; i <= 5; i++) feed(4'(i), 1'b0);
    if (FLUSH) begin
      chk("flush_partial", 32'(vout_valid), 32'h0);
    end else begin
      chk("noflush_word", vout, 32'hFED12345);
      chk("noflush_eol", 32'(vout_eol), 32'h0);
    end
    for (int i = 6; i <= 8; i++) feed(4'(i), 1'b0);
    if (FLUSH) chk("flush_slot0", vout, 32'h12345678);
    cyc();

    // Reset in the middle of a word.
    for (int i = 0; i < 5; i++) feed(4'h9, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_vout", vout, 32'h0);
    chk("midrst_valid", 32'(vout_valid), 32'h0);
    chk("midrst_eol", 32'(vout_eol), 32'h0);
    @(posedge clk); #1;
    chk("midrst_hold", vout, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(4'h8, 1'b0);
      if (i < 7) chk("postrst_no_early", 32'(vout_valid), 32'h0);
    end
    chk("postrst_word", vout, 32'h88888888);
    cyc();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      vin        = 4'($urandom_range(0, 15));
      vin_valid  = ($urandom_range(0, 3) != 0);
      vin_eol    = ($urandom_range(0, 5) == 0);
      vout_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    vin_valid = 1'b0; vin_eol = 1'b0; vout_ready = 1'b1;
    for (int c = 0; c < 3; c++) cyc();
    chk("drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dither_pixel_packer.md
DITHER_PIXEL_PACKER -- requirements
Module: dither_pixel_packer

Interface
REQ-001 SHALL have parameter OUTPUT_BITS, default 1, bits per pixel of the dithered stream (legal values 1 or 4).
REQ-002 SHALL derive localparam GW = OUTPUT_BITS*4 (group width: 4 pixels per group) and GPW = 32/GW (groups per word: 8 or 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port vin  input  GW  one dithered 4-pixel group, first pixel in MSBs.
REQ-006 SHALL have port vin_valid  input  1  vin holds a group.
REQ-007 SHALL have port vin_ready  output  1  packer accepts vin this cycle.
REQ-008 SHALL have port vin_eol  input  1  current group is the last of a scan line.
REQ-009 SHALL have port vout  output  32  packed word, earliest group in bits [31:32-GW].
REQ-010 SHALL have port vout_valid  output  1  vout holds a word.
REQ-011 SHALL have port vout_ready  input  1  consumer takes vout this cycle.
REQ-012 SHALL have port vout_eol  output  1  word closes a scan line; valid only with vout_valid.

Function
REQ-013 SHALL accept a group only on a cycle with vin_valid && vin_ready, and transfer a word only on a cycle with vout_valid && vout_ready.
REQ-014 SHALL keep a group counter cnt in 0..GPW-1 and a 32-bit accumulator; each accepted group is written to the slot at bits [31-cnt*GW -: GW].
REQ-015 SHALL treat an accepted group as completing when cnt == GPW-1, or when vin_eol is high and DITHER_PACK_LINE_FLUSH_EN is defined.
REQ-016 On a completing accept, SHALL load vout with the accumulator plus the new group, with all unwritten slots zero, set vout_valid, set vout_eol = vin_eol, clear cnt, and clear the accumulator.
REQ-017 On a non-completing accept, SHALL increment cnt.
REQ-018 SHALL present a completed word on vout/vout_valid the cycle after the completing accept (1-cycle latency).
REQ-019 SHALL drive vin_ready = !completing_slot || !vout_valid || vout_ready. Here completing_slot is cnt == GPW-1, or vin_eol under the flush macro. This is a combinational path from vout_ready.
REQ-020 SHALL hold vout and vout_eol stable while vout_valid && !vout_ready.
REQ-021 SHALL clear vout_valid after a transfer unless a completing accept occurs in the same cycle. On simultaneous transfer and completing accept, vout_valid SHALL stay 1 and the new word SHALL load.
REQ-022 SHALL accept non-completing groups regardless of output stall.

Reset
REQ-023 While rst is high, SHALL asynchronously force cnt=0, accumulator=0, vout=0, vout_valid=0, vout_eol=0.
REQ-024 SHALL discard any partial or pending word on reset mid-operation; the first group accepted after rst deasserts SHALL occupy slot 0.

Configuration
REQ-025 With macro DITHER_PACK_LINE_FLUSH_EN defined, a group accepted with vin_eol=1 SHALL close the word early: it is zero-padded and emitted with vout_eol=1.
REQ-026 Without DITHER_PACK_LINE_FLUSH_EN, vin_eol SHALL be ignored, words SHALL close only at cnt == GPW-1, and vout_eol SHALL be constant 0.

Verification
REQ-027 OUTPUT_BITS=1, vout_ready=1: groups 1,2,...,8 on consecutive cycles -> single vout=0x12345678, vout_valid for one cycle starting the cycle after group 8.
REQ-028 OUTPUT_BITS=4: groups 0xABCD, 0x1234 -> vout=0xABCD1234.
REQ-029 OUTPUT_BITS=1, vout_ready=0, 16 groups offered -> first word held stable; 7 groups of the second word accepted; vin_ready=0 on the 8th group until vout_ready=1; that cycle the 8th group is accepted and the second word loads.
REQ-030 Flush macro on, OUTPUT_BITS=1: groups 0xF, 0xE, 0xD with vin_eol on 0xD -> vout=0xFED00000, vout_eol=1; the next group lands in slot 0.
REQ-031 Assert rst after 5 accepted groups, then feed 0x8 x8 -> no output before the 8 new groups, then vout=0x88888888; all outputs read 0 during rst.
REQ-032 Flush macro off: same stimulus as REQ-030 -> no word emitted until 5 more groups arrive; vout_eol stays 0.
